// File: rtl/risc_toy_pkg.sv
// risc_toy_pkg: shared constants for the RISC_TOY memory responder.
//   - FSM state encodings (LOAD, RUN, HALT) kept as plain localparams so the
//     encoding stays visible to existing legacy code.
//   - Memory-mapped I/O offsets, the I/O select address bit and the DRW polarity.
package risc_toy_pkg;

    typedef logic [1:0] toy_state_t;

    localparam toy_state_t ST_LOAD = 2'd0;
    localparam toy_state_t ST_RUN  = 2'd1;
    localparam toy_state_t ST_HALT = 2'd2;

    localparam logic [1:0] IO_CYCLE  = 2'd0;
    localparam logic [1:0] IO_GPIO   = 2'd1;
    localparam logic [1:0] IO_TOHOST = 2'd2;

    localparam int unsigned IO_SEL_BIT = 29;

    localparam logic DRW_WRITE = 1'b1;

endpackage

// File: rtl/toy_mem_dp.sv
// toy_mem_dp: 2^AW x 32 word array with two synchronous ports.
//   Port A (fetch):  read-only; i_a_en loads o_a_rdata, i_a_zero forces the read to 0.
//   Port B (data):   i_b_we writes i_b_wdata; i_b_re loads o_b_rdata with either the
//                    array word or, when i_b_ext is set, i_b_ext_data (I/O reads share
//                    the same output register so the load path stays 1-cycle).
//   Both read registers reset to 0; the array itself is never cleared.
//   A port-A read and a port-B write to the same word on the same edge return the
//   old word (read-before-write).
module toy_mem_dp #(
    parameter int unsigned AW = 10
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic          i_a_en,
    input  logic          i_a_zero,
    input  logic [AW-1:0] i_a_addr,
    output logic [31:0]   o_a_rdata,
    input  logic          i_b_we,
    input  logic          i_b_re,
    input  logic [AW-1:0] i_b_addr,
    input  logic [31:0]   i_b_wdata,
    input  logic          i_b_ext,
    input  logic [31:0]   i_b_ext_data,
    output logic [31:0]   o_b_rdata
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_a_rdata;
    logic [31:0] r_b_rdata;

    always_ff @(posedge CLK) begin
        if (i_b_we) begin
            r_mem[i_b_addr] <= i_b_wdata;
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_a_rdata <= '0;
        end else if (i_a_en) begin
            r_a_rdata <= i_a_zero ? 32'd0 : r_mem[i_a_addr];
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_b_rdata <= '0;
        end else if (i_b_re) begin
            r_b_rdata <= i_b_ext ? i_b_ext_data : r_mem[i_b_addr];
        end
    end

    assign o_a_rdata = r_a_rdata;
    assign o_b_rdata = r_b_rdata;

endmodule

// File: rtl/risc_toy_mem.sv
// risc_toy_mem: memory-side responder for the RISC_TOY core.
//   Boot loader (LD_VALID/LD_DATA/LD_LAST/LD_READY) fills the array while the core is
//   held in reset (CORE_RSTN=0); LD_LAST releases the core.
//   Fetch port  (IREQ/IADDR/INSTR) and data port (DREQ/DRW/DADDR/DWDATA/DRDATA) are
//   served with 1-cycle latency in RUN. DADDR[29] selects the I/O window:
//   CYCLE counter, GPIO register, TOHOST (non-zero write halts), reserved.
//   HALT/TOHOST/GPIO/ERR/CORE_RSTN are registered; LD_READY is decoded from state.
module risc_toy_mem
    import risc_toy_pkg::*;
#(
    parameter int unsigned AW = 10,
    parameter int unsigned GW = 8
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic          IREQ,
    input  logic [29:0]   IADDR,
    output logic [31:0]   INSTR,
    input  logic          DREQ,
    input  logic          DRW,
    input  logic [29:0]   DADDR,
    input  logic [31:0]   DWDATA,
    output logic [31:0]   DRDATA,
    input  logic          LD_VALID,
    input  logic [31:0]   LD_DATA,
    input  logic          LD_LAST,
    output logic          LD_READY,
    output logic          CORE_RSTN,
    output logic          HALT,
    output logic [31:0]   TOHOST,
    output logic [GW-1:0] GPIO,
    output logic          ERR
);

    toy_state_t    r_state;
    logic [AW-1:0] r_ptr;
    logic [31:0]   r_cycle;
    logic [31:0]   r_tohost;
    logic [GW-1:0] r_gpio;
    logic          r_core_rstn;
    logic          r_halt;
    logic          r_err;

    logic          w_load;
    logic          w_run;
    logic          w_io_sel;
    logic [1:0]    w_io_off;
    logic          w_d_rd;
    logic          w_d_wr;
    logic          w_io_wr;
    logic          w_a_en;
    logic          w_a_zero;
    logic          w_b_we;
    logic [AW-1:0] w_b_addr;
    logic [31:0]   w_b_wdata;
    logic [31:0]   w_io_rdata;
    logic          w_unused_daddr;

    assign w_load   = (r_state == ST_LOAD);
    assign w_run    = (r_state == ST_RUN);
    assign w_io_sel = DADDR[IO_SEL_BIT];
    assign w_io_off = DADDR[1:0];
    assign w_d_rd   = w_run & DREQ & (DRW != DRW_WRITE);
    assign w_d_wr   = w_run & DREQ & (DRW == DRW_WRITE);
    assign w_io_wr  = w_d_wr & w_io_sel;

    // Array bits above AW alias onto the same word.
    assign w_unused_daddr = ^DADDR[28:AW];

    // Fetch from outside the array returns zero.
    assign w_a_en   = w_run & IREQ;
    assign w_a_zero = |IADDR[29:AW];

    // Loader and core stores never overlap (LOAD vs RUN), so they share port B.
    assign w_b_we    = (w_load & LD_VALID) | (w_d_wr & ~w_io_sel);
    assign w_b_addr  = w_load ? r_ptr : DADDR[AW-1:0];
    assign w_b_wdata = w_load ? LD_DATA : DWDATA;

    // CYCLE reads see the value before this edge's increment.
    always_comb begin
        w_io_rdata = '0;
        case (w_io_off)
            IO_CYCLE:  w_io_rdata = r_cycle;
            IO_GPIO:   w_io_rdata = 32'(r_gpio);
            IO_TOHOST: w_io_rdata = r_tohost;
            default:   w_io_rdata = '0;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state     <= ST_LOAD;
            r_ptr       <= '0;
            r_cycle     <= '0;
            r_tohost    <= '0;
            r_gpio      <= '0;
            r_core_rstn <= 1'b0;
            r_halt      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (LD_VALID) begin
                        r_ptr <= r_ptr + 1'b1;
                        if (&r_ptr) begin
                            r_err <= 1'b1;
                        end
                        if (LD_LAST) begin
                            r_state     <= ST_RUN;
                            r_core_rstn <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    r_cycle <= r_cycle + 32'd1;
                    if (w_io_wr) begin
                        case (w_io_off)
                            IO_GPIO: r_gpio <= DWDATA[GW-1:0];
                            IO_TOHOST: begin
                                if (DWDATA != 32'd0) begin
                                    r_tohost    <= DWDATA;
                                    r_halt      <= 1'b1;
                                    r_core_rstn <= 1'b0;
                                    r_state     <= ST_HALT;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                // HALT (and the unused encoding) hold everything until RSTN.
                default: ;
            endcase
        end
    end

    toy_mem_dp #(
        .AW (AW)
    ) u_mem (
        .CLK          (CLK),
        .RSTN         (RSTN),
        .i_a_en       (w_a_en),
        .i_a_zero     (w_a_zero),
        .i_a_addr     (IADDR[AW-1:0]),
        .o_a_rdata    (INSTR),
        .i_b_we       (w_b_we),
        .i_b_re       (w_d_rd),
        .i_b_addr     (w_b_addr),
        .i_b_wdata    (w_b_wdata),
        .i_b_ext      (w_io_sel),
        .i_b_ext_data (w_io_rdata),
        .o_b_rdata    (DRDATA)
    );

    assign LD_READY  = w_load;
    assign CORE_RSTN = r_core_rstn;
    assign HALT      = r_halt;
    assign TOHOST    = r_tohost;
    assign GPIO      = r_gpio;
    assign ERR       = r_err;

endmodule

// File: tb/tb_risc_toy_mem.sv
module tb_risc_toy_mem;

    localparam int unsigned AW = 10;
    localparam int unsigned GW = 8;
    localparam int DEPTH = 1 << AW;

    logic          CLK = 1'b0;
    logic          RSTN = 1'b0;
    logic          IREQ = 1'b0;
    logic [29:0]   IADDR = '0;
    logic [31:0]   INSTR;
    logic          DREQ = 1'b0;
    logic          DRW = 1'b0;
    logic [29:0]   DADDR = '0;
    logic [31:0]   DWDATA = '0;
    logic [31:0]   DRDATA;
    logic          LD_VALID = 1'b0;
    logic [31:0]   LD_DATA = '0;
    logic          LD_LAST = 1'b0;
    logic          LD_READY;
    logic          CORE_RSTN;
    logic          HALT;
    logic [31:0]   TOHOST;
    logic [GW-1:0] GPIO;
    logic          ERR;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: phase 0=load, 1=run, 2=halted.
    int            m_phase;
    int            m_ptr;
    bit            m_err;
    logic [31:0]   m_cycle;
    logic [31:0]   m_tohost;
    logic [GW-1:0] m_gpio;
    logic [31:0]   m_instr;
    logic [31:0]   m_drdata;
    bit            m_instr_ok;
    bit            m_drdata_ok;
    logic [31:0]   m_mem [DEPTH];
    bit            m_known [DEPTH];

    always #5 CLK = ~CLK;

    risc_toy_mem #(
        .AW (AW),
        .GW (GW)
    ) dut (
        .CLK       (CLK),
        .RSTN      (RSTN),
        .IREQ      (IREQ),
        .IADDR     (IADDR),
        .INSTR     (INSTR),
        .DREQ      (DREQ),
        .DRW       (DRW),
        .DADDR     (DADDR),
        .DWDATA    (DWDATA),
        .DRDATA    (DRDATA),
        .LD_VALID  (LD_VALID),
        .LD_DATA   (LD_DATA),
        .LD_LAST   (LD_LAST),
        .LD_READY  (LD_READY),
        .CORE_RSTN (CORE_RSTN),
        .HALT      (HALT),
        .TOHOST    (TOHOST),
        .GPIO      (GPIO),
        .ERR       (ERR)
    );

    task automatic model_reset();
        m_phase = 0; m_ptr = 0; m_err = 0; m_cycle = 0; m_tohost = 0; m_gpio = 0;
        m_instr = 0; m_drdata = 0; m_instr_ok = 1; m_drdata_ok = 1;
    endtask

    // Apply the current inputs to the model as one clock edge.
    task automatic model_edge();
        int fidx;
        int didx;
        int off;
        if (m_phase == 0) begin
            if (LD_VALID) begin
                m_mem[m_ptr] = LD_DATA;
                m_known[m_ptr] = 1;
                if (m_ptr == DEPTH - 1) begin
                    m_err = 1;
                    m_ptr = 0;
                end else begin
                    m_ptr = m_ptr + 1;
                end
                if (LD_LAST) m_phase = 1;
            end
        end else if (m_phase == 1) begin
            fidx = int'(IADDR % DEPTH);
            didx = int'(DADDR % DEPTH);
            off  = int'(DADDR % 4);
            if (IREQ) begin
                if (IADDR / DEPTH != 0) begin
                    m_instr = 0; m_instr_ok = 1;
                end else begin
                    m_instr = m_mem[fidx]; m_instr_ok = m_known[fidx];
                end
            end
            if (DREQ) begin
                if (DADDR >= 30'h2000_0000) begin
                    if (DRW) begin
                        if (off == 1) m_gpio = DWDATA[GW-1:0];
                        if (off == 2 && DWDATA != 0) begin
                            m_tohost = DWDATA;
                            m_phase = 2;
                        end
                    end else begin
                        m_drdata_ok = 1;
                        if (off == 0) m_drdata = m_cycle;
                        else if (off == 1) m_drdata = {24'd0, m_gpio};
                        else if (off == 2) m_drdata = m_tohost;
                        else m_drdata = 0;
                    end
                end else if (DRW) begin
                    m_mem[didx] = DWDATA;
                    m_known[didx] = 1;
                end else begin
                    m_drdata = m_mem[didx];
                    m_drdata_ok = m_known[didx];
                end
            end
            m_cycle = m_cycle + 1;
        end
    endtask

    task automatic cyc();
        model_edge();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        IREQ = 0; IADDR = '0; DREQ = 0; DRW = 0; DADDR = '0; DWDATA = '0;
        LD_VALID = 0; LD_DATA = '0; LD_LAST = 0;
    endtask

    task automatic do_reset();
        idle();
        RSTN = 0;
        model_reset();
        @(posedge CLK);
        #1;
        RSTN = 1;
    endtask

    task automatic load_word(input logic [31:0] data, input bit last);
        LD_VALID = 1; LD_DATA = data; LD_LAST = last;
        cyc();
        LD_VALID = 0; LD_LAST = 0;
    endtask

    task automatic dwrite(input logic [29:0] addr, input logic [31:0] data);
        DREQ = 1; DRW = 1; DADDR = addr; DWDATA = data;
        cyc();
        DREQ = 0; DRW = 0;
    endtask

    task automatic dread(input logic [29:0] addr);
        DREQ = 1; DRW = 0; DADDR = addr;
        cyc();
        DREQ = 0;
    endtask

    task automatic fetch(input logic [29:0] addr);
        IREQ = 1; IADDR = addr;
        cyc();
        IREQ = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++; if (INSTR !== 32'd0) begin n_fail++; $display("FAIL reset_instr: got %h want 0", INSTR); end
        n_tests++; if (DRDATA !== 32'd0) begin n_fail++; $display("FAIL reset_drdata: got %h want 0", DRDATA); end
        n_tests++; if ({CORE_RSTN, HALT, ERR, LD_READY} !== 4'b0001) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want 0001 (core_rstn,halt,err,ld_ready)", {CORE_RSTN, HALT, ERR, LD_READY}); end
        n_tests++; if (TOHOST !== 32'd0 || GPIO !== '0) begin
            n_fail++; $display("FAIL reset_regs: tohost %h gpio %h want 0", TOHOST, GPIO); end
    endtask

    task automatic test_load();
        load_word(32'h11, 0);
        load_word(32'h22, 0);
        load_word(32'h33, 0);
        n_tests++; if (CORE_RSTN !== 1'b0 || LD_READY !== 1'b1) begin
            n_fail++; $display("FAIL load_hold: core_rstn %b ld_ready %b want 0 1", CORE_RSTN, LD_READY); end
        load_word(32'h44, 1);
        n_tests++; if (CORE_RSTN !== 1'b1 || LD_READY !== 1'b0) begin
            n_fail++; $display("FAIL load_release: core_rstn %b ld_ready %b want 1 0", CORE_RSTN, LD_READY); end
    endtask

    task automatic test_fetch();
        logic [29:0] oob;
        fetch(30'd2);
        n_tests++; if (INSTR !== 32'h33) begin n_fail++; $display("FAIL fetch_2: got %h want 33", INSTR); end
        oob = 30'd2 | (30'd1 << AW);
        fetch(oob);
        n_tests++; if (INSTR !== 32'd0) begin n_fail++; $display("FAIL fetch_oob: got %h want 0", INSTR); end
        fetch(30'd3);
        IADDR = 30'd1;
        cyc();
        n_tests++; if (INSTR !== 32'h44) begin n_fail++; $display("FAIL fetch_hold: got %h want 44", INSTR); end
        // Loader input outside LOAD must not touch the array.
        LD_VALID = 1; LD_DATA = 32'hBAD; cyc(); LD_VALID = 0;
        fetch(30'd0);
        n_tests++; if (INSTR !== 32'h11) begin n_fail++; $display("FAIL ld_ignored: got %h want 11", INSTR); end
    endtask

    task automatic test_store_load();
        dwrite(30'd5, 32'h55);
        IREQ = 1; IADDR = 30'd5;
        dwrite(30'd5, 32'hDEADBEEF);
        IREQ = 0;
        n_tests++; if (INSTR !== 32'h55) begin n_fail++; $display("FAIL rbw_fetch: got %h want 55", INSTR); end
        n_tests++; if (DRDATA !== 32'd0) begin n_fail++; $display("FAIL write_keeps_drdata: got %h want 0", DRDATA); end
        dread(30'd5);
        n_tests++; if (DRDATA !== 32'hDEADBEEF) begin n_fail++; $display("FAIL dread_5: got %h want deadbeef", DRDATA); end
        dwrite(30'd6 | (30'd1 << 20), 32'hCAFE);
        dread(30'd6);
        n_tests++; if (DRDATA !== 32'hCAFE) begin n_fail++; $display("FAIL alias_6: got %h want cafe", DRDATA); end
    endtask

    task automatic test_io();
        dwrite(30'h2000_0001, 32'h1A5);
        n_tests++; if (GPIO !== 8'hA5) begin n_fail++; $display("FAIL gpio_out: got %h want a5", GPIO); end
        dread(30'h2000_0001);
        n_tests++; if (DRDATA !== 32'hA5) begin n_fail++; $display("FAIL gpio_rd: got %h want a5", DRDATA); end
        dwrite(30'h2000_0000, 32'hFFFF);
        dread(30'h2000_0000);
        n_tests++; if (DRDATA !== m_cycle - 32'd1) begin
            n_fail++; $display("FAIL cycle_rd: got %0d want %0d", DRDATA, m_cycle - 32'd1); end
        dread(30'h2000_0003);
        n_tests++; if (DRDATA !== 32'd0) begin n_fail++; $display("FAIL reserved_rd: got %h want 0", DRDATA); end
    endtask

    task automatic test_tohost();
        dwrite(30'h2000_0002, 32'd0);
        n_tests++; if (HALT !== 1'b0 || CORE_RSTN !== 1'b1) begin
            n_fail++; $display("FAIL tohost0: halt %b core_rstn %b want 0 1", HALT, CORE_RSTN); end
        dwrite(30'h2000_0002, 32'd7);
        n_tests++; if (HALT !== 1'b1 || CORE_RSTN !== 1'b0 || TOHOST !== 32'd7) begin
            n_fail++; $display("FAIL tohost7: halt %b core_rstn %b tohost %h want 1 0 7", HALT, CORE_RSTN, TOHOST); end
        dwrite(30'd5, 32'h12345678);
        dwrite(30'h2000_0001, 32'h33);
        n_tests++; if (GPIO !== 8'hA5 || TOHOST !== 32'd7 || LD_READY !== 1'b0) begin
            n_fail++; $display("FAIL halt_frozen: gpio %h tohost %h ld_ready %b want a5 7 0", GPIO, TOHOST, LD_READY); end
        do_reset();
        n_tests++; if (GPIO !== '0 || HALT !== 1'b0) begin
            n_fail++; $display("FAIL halt_reset: gpio %h halt %b want 0 0", GPIO, HALT); end
        load_word(32'h99, 1);
        fetch(30'd5);
        n_tests++; if (INSTR !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL halt_store_ignored: got %h want deadbeef", INSTR); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < DEPTH - 1; i++) load_word(32'h1000_0000 + 32'(i), 0);
        n_tests++; if (ERR !== 1'b0) begin n_fail++; $display("FAIL err_early: got %b want 0", ERR); end
        load_word(32'h1000_0000 + 32'(DEPTH - 1), 0);
        n_tests++; if (ERR !== 1'b1) begin n_fail++; $display("FAIL err_wrap: got %b want 1", ERR); end
        load_word(32'h1000_0000 + 32'(DEPTH), 1);
        fetch(30'd0);
        n_tests++; if (INSTR !== 32'h1000_0000 + 32'(DEPTH)) begin
            n_fail++; $display("FAIL wrap_word0: got %h want %h", INSTR, 32'h1000_0000 + 32'(DEPTH)); end
        fetch(30'd1);
        n_tests++; if (INSTR !== 32'h1000_0001) begin n_fail++; $display("FAIL wrap_word1: got %h want 10000001", INSTR); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            IREQ = 1'($urandom);
            IADDR = ($urandom_range(7) == 0) ? 30'($urandom) : 30'($urandom_range(DEPTH - 1));
            DREQ = 1'($urandom);
            DRW = 1'($urandom);
            DWDATA = $urandom;
            if ($urandom_range(3) == 0) DADDR = {1'b1, 27'($urandom), 2'($urandom)};
            else DADDR = {1'b0, 29'($urandom)};
            // Keep the core running: TOHOST writes carry zero.
            if (DADDR[29] && DADDR[1:0] == 2'd2) DWDATA = 32'd0;
            LD_VALID = 1'($urandom); LD_DATA = $urandom; LD_LAST = 1'($urandom);
            cyc();
            if (m_instr_ok) begin
                n_tests++; if (INSTR !== m_instr) begin
                    n_fail++; $display("FAIL rand_instr[%0d]: got %h want %h", i, INSTR, m_instr); end
            end
            if (m_drdata_ok) begin
                n_tests++; if (DRDATA !== m_drdata) begin
                    n_fail++; $display("FAIL rand_drdata[%0d]: got %h want %h", i, DRDATA, m_drdata); end
            end
            n_tests++; if (GPIO !== m_gpio || TOHOST !== m_tohost) begin
                n_fail++; $display("FAIL rand_io[%0d]: gpio %h tohost %h want %h %h", i, GPIO, TOHOST, m_gpio, m_tohost); end
            n_tests++; if (CORE_RSTN !== (m_phase == 1) || HALT !== (m_phase == 2) || ERR !== m_err) begin
                n_fail++; $display("FAIL rand_ctrl[%0d]: core_rstn %b halt %b err %b want phase %0d err %b",
                                    i, CORE_RSTN, HALT, ERR, m_phase, m_err); end
        end
        idle();
    endtask

    task automatic test_rstn_mid_run();
        logic [31:0] exp5;
        dwrite(30'h2000_0001, 32'h5A);
        dread(30'd7);
        #2;
        RSTN = 0;
        #1;
        n_tests++; if ({INSTR, DRDATA, TOHOST} !== 96'd0 || GPIO !== '0) begin
            n_fail++; $display("FAIL async_rst_data: instr %h drdata %h tohost %h gpio %h want 0", INSTR, DRDATA, TOHOST, GPIO); end
        n_tests++; if ({CORE_RSTN, HALT, ERR, LD_READY} !== 4'b0001) begin
            n_fail++; $display("FAIL async_rst_ctrl: got %b want 0001", {CORE_RSTN, HALT, ERR, LD_READY}); end
        model_reset();
        @(posedge CLK);
        #1;
        RSTN = 1;
        exp5 = m_mem[5];
        load_word(32'h77, 1);
        dread(30'h2000_0000);
        n_tests++; if (DRDATA !== 32'd0) begin n_fail++; $display("FAIL cycle_after_rst: got %0d want 0", DRDATA); end
        dread(30'h2000_0000);
        n_tests++; if (DRDATA !== 32'd1) begin n_fail++; $display("FAIL cycle_next: got %0d want 1", DRDATA); end
        fetch(30'd5);
        n_tests++; if (INSTR !== exp5) begin n_fail++; $display("FAIL mem_kept: got %h want %h", INSTR, exp5); end
        fetch(30'd0);
        n_tests++; if (INSTR !== 32'h77) begin n_fail++; $display("FAIL reload_word0: got %h want 77", INSTR); end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) m_known[i] = 0;
        model_reset();
        test_reset();
        test_load();
        test_fetch();
        test_store_load();
        test_io();
        test_tohost();
        test_overflow();
        test_random();
        test_rstn_mid_run();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/risc_toy_mem.md
# risc_toy_mem

Memory-side responder for the RISC_TOY core: it answers the core's instruction-fetch port (IREQ/IADDR/INSTR) and data port (DREQ/DRW/DADDR/DWDATA/DRDATA) from one shared word array. It adds a small memory-mapped I/O window: a cycle counter, a GPIO register, and a TOHOST halt register. A boot loader fills the array from an external stream while the core is held in reset, then releases the core.

## Interface
- AW, 10, word-address width of the array (2^AW words)
- GW, 8, GPIO register width
- CLK  in  1  clock
- RSTN  in  1  reset, asynchronous, active-low
- IREQ  in  1  fetch request
- IADDR  in  30  fetch word address
- INSTR  out  32  fetched instruction
- DREQ  in  1  data request
- DRW  in  1  1 = write, 0 = read
- DADDR  in  30  data word address
- DWDATA  in  32  store data
- DRDATA  out  32  load data
- LD_VALID  in  1  loader word valid
- LD_DATA  in  32  loader word
- LD_LAST  in  1  final loader word (qualified by LD_VALID)
- LD_READY  out  1  loader accept; high only in LOAD
- CORE_RSTN  out  1  active-low reset to the core
- HALT  out  1  program finished
- TOHOST  out  32  value written to TOHOST
- GPIO  out  GW  GPIO register
- ERR  out  1  sticky: loader pointer wrapped

## Operation
- FSM states:
  - LOAD (reset state): LD_READY=1, CORE_RSTN=0. Each LD_VALID cycle writes LD_DATA to mem[ptr] and increments ptr. LD_VALID&LD_LAST → RUN.
  - RUN: CORE_RSTN=1; the I and D ports are served.
  - HALT: CORE_RSTN=0; the ports are ignored. Exit only by RSTN.
- Loader pointer: ptr is AW bits and starts at 0. Accepting a word at ptr=2^AW−1 wraps ptr to 0 and sets ERR.
- Address decode: DADDR[29]=0 selects the array, indexed by DADDR[AW-1:0]. Array bits DADDR[28:AW] are ignored.
- I/O decode: DADDR[29]=1 selects I/O, with offset DADDR[1:0]:
  - 0: CYCLE, read-only; writes are ignored.
  - 1: GPIO, read/write; read data is zero-extended.
  - 2: TOHOST, write sets TOHOST and HALT (only if data ≠ 0); reads return TOHOST.
  - 3: reserved; reads return 0 and writes are ignored.
- Fetch: IREQ in RUN gives INSTR = mem[IADDR[AW-1:0]] at the next edge. If IADDR[29:AW]≠0, INSTR = 0. With IREQ low, INSTR holds its value.
- Data reads: DREQ&~DRW loads DRDATA at the next edge. With no read, DRDATA holds its value.
- Data writes: DREQ&DRW writes at the edge. DRDATA is unchanged.
- Same-cycle fetch and data write to the same word: INSTR returns the old data (read-before-write).
- CYCLE: 32 bits, cleared by reset, increments every RUN cycle, wraps at 2^32−1→0, and freezes in LOAD and HALT.
- Array contents are not cleared by reset.

## Timing
- Output reset values: INSTR=0, DRDATA=0, CORE_RSTN=0, HALT=0, TOHOST=0, GPIO=0, ERR=0. LD_READY=1 because the FSM resets to LOAD.
- Read latency is 1 cycle on both ports. There is no wait/ready signalling toward the core.
- All outputs are registered except LD_READY, which is decoded from the state.
- CORE_RSTN rises on the edge that accepts LD_LAST. The first core fetch can therefore arrive the following cycle.
- TOHOST write: HALT and CORE_RSTN=0 take effect at the same edge that latches TOHOST.
- Requests in the HALT cycle and later have no effect.
- A data read of CYCLE returns the value before that edge's increment.
- LD_VALID outside LOAD is ignored.
- RSTN asserted mid-RUN or mid-LOAD: immediate return to LOAD with ptr=0 and every output at its reset value.

## Structure
- Package risc_toy_pkg:
  - FSM state enum: LOAD, RUN, HALT.
  - I/O offset constants: IO_CYCLE=0, IO_GPIO=1, IO_TOHOST=2.
  - IO select bit index: 29.
  - DRW_WRITE=1.
- Sub-module toy_mem_dp: 2^AW×32 array with one synchronous read port (fetch) and one synchronous read/write port (data/loader), read-before-write.
- The loader writes through the data port. Loader and data writes never share a cycle, because they run in different states.

## Test plan
- Load 4 words 0x11,0x22,0x33,0x44 with LD_LAST on the 4th → CORE_RSTN rises that edge; IADDR=2 fetch gives INSTR=0x33 one cycle later.
- Store 0xDEADBEEF to DADDR=5, then read DADDR=5 → DRDATA=0xDEADBEEF one cycle after the read request. A same-cycle fetch of IADDR=5 during the store returns the old word.
- Write GPIO (DADDR=0x20000001) with 0x1A5 → GPIO=0xA5; a readback gives 0x000000A5. A CYCLE read after N RUN cycles returns N−1 (read-before-increment).
- Write TOHOST 0 → no halt. Write TOHOST 7 → HALT=1, TOHOST=7, CORE_RSTN=0 at that edge. A following store to DADDR=5 leaves the array unchanged.
- Load 2^AW+1 words → ERR=1 and mem[0] holds word 2^AW. Pulse RSTN mid-RUN → all outputs reset, LD_READY=1, CYCLE=0, array contents preserved.
